// File: rtl/dbus_mem_responder_if.sv
// rtl/dbus_mem_responder_if.sv - load/store request and response signals between the memory stage and the data RAM
interface dbus_mem_responder_if;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data, resp_err
  );
endinterface

// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - single-outstanding data-bus responder over a word-organised 64-bit RAM
module dbus_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  dbus_mem_responder_if.slave        bus,
  output logic [31:0]                rd_count,
  output logic [31:0]                wr_count
);
  localparam int         AW     = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic [7:0]  strobe_q;
  logic [63:0] data_q;

  logic        addr_ok_q;
  logic        data_ok_q;
  logic [63:0] resp_data_q;
  logic        resp_err_q;

  logic [63:0] mem [MEM_WORDS];

  logic [63:0] src_addr;
  logic [2:0]  src_size;
  logic        misaligned;
  logic        size_bad;
  logic        out_of_range;
  logic        req_bad;
  logic [AW-1:0] idx;
  logic [63:0] rd_word;
  logic        enter_resp;

  // In IDLE the live request is decoded so a LATENCY=1 response can be
  // registered at the accepting edge; afterwards the latched copy is used.
  always_comb begin
    src_addr   = (state == S_IDLE) ? bus.req_addr : addr_q;
    src_size   = (state == S_IDLE) ? bus.req_size : size_q;
    misaligned = 1'b0;
    size_bad   = 1'b0;
    case (src_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = src_addr[0];
      3'd2:    misaligned = |src_addr[1:0];
      3'd3:    misaligned = |src_addr[2:0];
      default: size_bad   = 1'b1;
    endcase
    out_of_range = |(src_addr >> (3 + AW));
    req_bad      = misaligned | size_bad | out_of_range;
    idx          = src_addr[3 +: AW];
  end

  assign rd_word = mem[idx];

  always_comb begin
    enter_resp = 1'b0;
    case (state)
      S_IDLE:  enter_resp = bus.req_valid && (LATENCY == 1);
      S_WAIT:  enter_resp = (cnt <= 4'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      addr_q      <= 64'd0;
      size_q      <= 3'd0;
      strobe_q    <= 8'd0;
      data_q      <= 64'd0;
      addr_ok_q   <= 1'b0;
      data_ok_q   <= 1'b0;
      resp_data_q <= 64'd0;
      resp_err_q  <= 1'b0;
      rd_count    <= 32'd0;
      wr_count    <= 32'd0;
    end else begin
      addr_ok_q   <= 1'b0;
      data_ok_q   <= enter_resp;
      resp_err_q  <= enter_resp & req_bad;
      resp_data_q <= (enter_resp && !req_bad) ? rd_word : 64'd0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q    <= bus.req_addr;
            size_q    <= bus.req_size;
            strobe_q  <= bus.req_strobe;
            data_q    <= bus.req_data;
            addr_ok_q <= 1'b1;
            cnt       <= LAT_M1;
            state     <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (enter_resp) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          if (!req_bad) begin
            if (strobe_q != 8'd0) begin
              wr_count <= wr_count + 32'd1;
            end else begin
              rd_count <= rd_count + 32'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The store lands on the edge that closes RESP, after the old word was returned.
  always_ff @(posedge clk) begin
    if (reset && state == S_RESP && !req_bad && strobe_q != 8'd0) begin
      for (int b = 0; b < 8; b++) begin
        if (strobe_q[b]) begin
          mem[idx][8*b +: 8] <= data_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.resp_addr_ok = addr_ok_q;
  assign bus.resp_data_ok = data_ok_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_err     = resp_err_q;
endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Data-bus responder at the far end of the memory stage's load/store requests (LD/LB/LH/LW/LBU/LHU/LWU, SD/SB/SH/SW).
- Backed by a word-organised 64-bit data RAM.
- Accepts one request at a time, waits a programmable latency, then returns read data or commits a byte-strobed write.
- Flags misaligned and out-of-range accesses so the pipeline can raise LOADERROR/STOREERROR; serves as the simulation data memory for the core.

Parameters:
- MEM_WORDS, 1024: number of 64-bit words; power of two.
- LATENCY, 2: cycles from acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present; initiator holds it and all req_* stable until it sees resp_data_ok.
- req_addr  in  64  byte address.
- req_size  in  3  access size: 0=1B, 1=2B, 2=4B, 3=8B; 4..7 illegal.
- req_strobe  in  8  byte-lane write enables; 0 means read.
- req_data  in  64  write data, already lane-aligned.
- resp_addr_ok  out  1  request accepted, one-cycle pulse.
- resp_data_ok  out  1  response valid, one-cycle pulse.
- resp_data  out  64  full aligned word, raw; lane extraction and sign extension are done by the memory stage.
- resp_err  out  1  qualified by resp_data_ok: misaligned, illegal size, or out of range.
- rd_count  out  32  completed good reads.
- wr_count  out  32  completed good writes.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0, FSM to IDLE, latency counter to 0, latched request cleared.
  - RAM contents are not reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if req_valid=1 at a rising edge, latch addr/size/strobe/data and pulse resp_addr_ok for the next cycle. Load the counter with LATENCY-1. Go to RESP if LATENCY=1, else WAIT.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
  - RESP: resp_data_ok=1 for exactly one cycle with resp_data and resp_err valid, then return to IDLE.
- Timing:
  - A request sampled at edge k gives resp_addr_ok high in cycle k+1 and resp_data_ok high in cycle k+LATENCY.
  - With LATENCY=1, both pulses occur in the same cycle.
  - resp_data_ok and resp_data are registered, not combinational from req_*.
- Changes on req_* after acceptance are ignored until resp_data_ok.
- If req_valid is still 1 in the IDLE cycle after RESP, it is accepted as a new request. Initiators must deassert or change the request in the cycle after data_ok.
- Indexing: word index = addr[3 +: log2(MEM_WORDS)].
  - Out of range: any addr bit above 3+log2(MEM_WORDS)-1 is set.
- Misaligned: addr[2:0] not a multiple of 2^size.
- Error response (out of range, misaligned, or size>3):
  - resp_err=1, resp_data=0.
  - No RAM write; counters unchanged.
- Good read:
  - resp_data = RAM word at index; resp_err=0; rd_count+1.
- Good write (strobe≠0):
  - Bytes with strobe[i]=1 are written at the edge ending the RESP cycle; other bytes are preserved.
  - resp_data returns the old word.
  - wr_count+1.
  - Strobe lanes are not cross-checked against size.
- Reset mid-operation (WAIT or RESP before the final edge): the request is aborted, no write is committed, and no data_ok is produced.
- Counters wrap modulo 2^32.

Test Plan:
- LATENCY=2; after reset, write word 0 with 0x1122334455667788 (addr 0x0, size 3, strobe 0xFF), then read addr 0x0 → addr_ok in cycle k+1; data_ok in cycle k+2 with 0x1122334455667788; wr_count=1, rd_count=1.
- Byte write addr 0x13 (size 0, strobe 0x08, data 0x00000000AB000000) onto word 2 preloaded 0 → read addr 0x10 returns 0x00000000AB000000; the other bytes stay 0.
- Misaligned: read addr 0x6 with size 2 → data_ok with resp_err=1, data 0, rd_count unchanged. Store addr 0x4 with size 3, strobe 0xFF → resp_err=1 and the word is unchanged.
- Out of range with MEM_WORDS=1024: addr 0x2000 → resp_err=1, no write.
- Back-to-back: req_valid held high across two different requests → exactly one data_ok per request, separated by LATENCY+1 cycles; the second is accepted in the IDLE cycle after RESP.
- Reset asserted in WAIT of a store of 0xFF.. to word 5 (preloaded 0x5) → no data_ok; word 5 still reads 0x5 after reset release; all outputs are 0 while reset=0.
